// File: rtl/gpio_prime_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : gpio_prime_engine                                            |
// | Description : Bus-mapped k-th prime engine. Request indices k are queued   |
// |               in a request FIFO. A sequential trial-division search finds  |
// |               the k-th prime, and {prime, tag} results are queued in a     |
// |               result FIFO that is read back through the W register.        |
// |               Sticky range/overflow/wrap flags are reported in S.          |
// | Ports       : clk        - system clock, rising edge                       |
// |               n_reset    - asynchronous active-low reset                   |
// |               saddress   - bus address, valid with srd/swr                 |
// |               srd / swr  - single-cycle read / write strobes              |
// |               sdata_in   - write data                                      |
// |               sdata_out  - registered read data (1-cycle latency)          |
// |               irq        - result/flag interrupt (PRIME_IRQ_EN only)       |
// | Options     : `define PRIME_IRQ_EN adds the registered irq output.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module gpio_prime_engine #(
    parameter logic [15:0] BASE_ADDR = 16'h00EC,
    parameter int          N_WIDTH   = 10,
    parameter int          W_WIDTH   = 13,
    parameter int          MAX_N     = 1000,
    parameter int          REQ_DEPTH = 4,
    parameter int          RES_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] saddress,
    input  logic        srd,
    input  logic        swr,
    input  logic [31:0] sdata_in,
    output logic [31:0] sdata_out
`ifdef PRIME_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int c_RQ_AW = $clog2(REQ_DEPTH);
    localparam int c_RS_AW = $clog2(RES_DEPTH);

    localparam logic [15:0] c_ADDR_A   = BASE_ADDR;
    localparam logic [15:0] c_ADDR_CLR = BASE_ADDR + 16'h0008;
    localparam logic [15:0] c_ADDR_W   = BASE_ADDR + 16'h0010;
    localparam logic [15:0] c_ADDR_S   = BASE_ADDR + 16'h0018;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CAND  = 3'd1;
    localparam logic [2:0] c_DIV   = 3'd2;
    localparam logic [2:0] c_PRIME = 3'd3;
    localparam logic [2:0] c_COMP  = 3'd4;
    localparam logic [2:0] c_PUSH  = 3'd5;

    localparam logic [N_WIDTH-1:0] c_MAX_K   = N_WIDTH'(MAX_N);
    localparam logic [N_WIDTH-1:0] c_K_ONE   = N_WIDTH'(1);
    localparam logic [c_RQ_AW:0]   c_RQ_FULL = (c_RQ_AW+1)'(REQ_DEPTH);
    localparam logic [c_RS_AW:0]   c_RS_FULL = (c_RS_AW+1)'(RES_DEPTH);
    localparam logic [W_WIDTH-1:0] c_TWO     = W_WIDTH'(2);
    localparam logic [W_WIDTH-1:0] c_THREE   = W_WIDTH'(3);

    // ---------------- storage ----------------
    logic [N_WIDTH-1:0] r_req_k   [REQ_DEPTH];
    logic [3:0]         r_req_tag [REQ_DEPTH];
    logic [c_RQ_AW-1:0] r_req_wp, r_req_rp;
    logic [c_RQ_AW:0]   r_req_cnt;

    logic [W_WIDTH-1:0] r_res_prime [RES_DEPTH];
    logic [3:0]         r_res_tag   [RES_DEPTH];
    logic [c_RS_AW-1:0] r_res_wp, r_res_rp;
    logic [c_RS_AW:0]   r_res_cnt;

    logic [2:0]         r_state;
    logic [N_WIDTH-1:0] r_k, r_cnt;
    logic [3:0]         r_tag, r_seq;
    logic [W_WIDTH-1:0] r_cand, r_d;
    logic [7:0]         r_total;
    logic               r_err_range, r_ovf, r_err_wrap;
    logic [31:0]        r_sdata;

    // ---------------- bus decode ----------------
    logic w_rd, w_wr_a, w_clr, w_rd_w, w_rd_s;
    logic [N_WIDTH-1:0] w_k;
    logic w_k_ok;
    logic w_unused;

    assign w_rd   = srd & ~swr;   // a simultaneous write wins over the read
    assign w_wr_a = swr && (saddress == c_ADDR_A);
    assign w_clr  = swr && (saddress == c_ADDR_CLR);
    assign w_rd_w = w_rd && (saddress == c_ADDR_W);
    assign w_rd_s = w_rd && (saddress == c_ADDR_S);
    assign w_k    = sdata_in[N_WIDTH-1:0];
    assign w_k_ok = (w_k != '0) && (w_k <= c_MAX_K);
    assign w_unused = &{1'b0, sdata_in[31:N_WIDTH]};

    // ---------------- FIFO control ----------------
    logic w_req_empty, w_req_full, w_req_pop, w_req_push, w_ovf_set, w_rng_set;
    logic w_res_empty, w_res_full, w_res_pop, w_res_push, w_res_push_ok;

    assign w_req_empty = (r_req_cnt == '0);
    assign w_req_full  = (r_req_cnt == c_RQ_FULL);
    assign w_res_empty = (r_res_cnt == '0);
    assign w_res_full  = (r_res_cnt == c_RS_FULL);

    assign w_req_pop  = (r_state == c_IDLE) && !w_req_empty && !w_res_full && !w_clr;
    // A full request FIFO still accepts a push when the engine pops it this cycle
    assign w_req_push = w_wr_a && w_k_ok && (!w_req_full || w_req_pop);
    assign w_ovf_set  = w_wr_a && w_k_ok && w_req_full && !w_req_pop;
    assign w_rng_set  = w_wr_a && !w_k_ok;

    assign w_res_pop     = w_rd_w && !w_res_empty;
    assign w_res_push_ok = w_res_push && !w_clr && (!w_res_full || w_res_pop);

    // ---------------- search datapath ----------------
    logic [2*W_WIDTH-1:0] w_sq;
    logic [W_WIDTH-1:0]   w_rem;
    logic [W_WIDTH:0]     w_next_wide;
    logic [N_WIDTH-1:0]   w_cnt_inc;

    assign w_sq        = {{W_WIDTH{1'b0}}, r_d} * {{W_WIDTH{1'b0}}, r_d};
    assign w_rem       = r_cand % r_d;
    // After 2 the only remaining candidates are odd, so step by 2
    assign w_next_wide = {1'b0, r_cand} + ((r_cand == c_TWO) ? (W_WIDTH+1)'(1) : (W_WIDTH+1)'(2));
    assign w_cnt_inc   = r_cnt + c_K_ONE;

    logic [2:0]         w_state_nxt;
    logic [N_WIDTH-1:0] w_k_nxt, w_cnt_nxt;
    logic [3:0]         w_tag_nxt;
    logic [W_WIDTH-1:0] w_cand_nxt, w_d_nxt, w_res_din;
    logic               w_wrap_set, w_total_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_cnt_nxt   = r_cnt;
        w_tag_nxt   = r_tag;
        w_cand_nxt  = r_cand;
        w_d_nxt     = r_d;
        w_res_push  = 1'b0;
        w_res_din   = r_cand;
        w_wrap_set  = 1'b0;
        w_total_inc = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_req_pop) begin
                    w_k_nxt     = r_req_k[r_req_rp];
                    w_tag_nxt   = r_req_tag[r_req_rp];
                    w_cand_nxt  = c_TWO;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_CAND;
                end
            end
            c_CAND: begin
                if (r_cand == c_TWO) begin
                    w_state_nxt = c_PRIME;
                end else if (!r_cand[0]) begin
                    w_state_nxt = c_COMP;
                end else begin
                    w_d_nxt     = c_THREE;
                    w_state_nxt = c_DIV;
                end
            end
            c_DIV: begin
                if (w_sq > {{W_WIDTH{1'b0}}, r_cand}) begin
                    w_state_nxt = c_PRIME;
                end else if (w_rem == '0) begin
                    w_state_nxt = c_COMP;
                end else begin
                    w_d_nxt = r_d + c_TWO;
                end
            end
            c_PRIME, c_COMP: begin
                if (r_state == c_PRIME) begin
                    w_cnt_nxt = w_cnt_inc;
                end
                if ((r_state == c_PRIME) && (w_cnt_inc == r_k)) begin
                    w_state_nxt = c_PUSH;
                end else if (w_next_wide[W_WIDTH]) begin
                    // Candidate space exhausted: report prime 0 for this tag
                    w_wrap_set  = 1'b1;
                    w_res_push  = 1'b1;
                    w_res_din   = '0;
                    w_state_nxt = c_IDLE;
                end else begin
                    w_cand_nxt  = w_next_wide[W_WIDTH-1:0];
                    w_state_nxt = c_CAND;
                end
            end
            c_PUSH: begin
                w_res_push  = 1'b1;
                w_total_inc = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
        if (w_clr) begin
            w_state_nxt = c_IDLE;
        end
    end

    // ---------------- state and control registers ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= c_IDLE;
            r_k         <= '0;
            r_cnt       <= '0;
            r_tag       <= '0;
            r_cand      <= '0;
            r_d         <= '0;
            r_seq       <= '0;
            r_total     <= '0;
            r_err_range <= 1'b0;
            r_ovf       <= 1'b0;
            r_err_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tag   <= w_tag_nxt;
            r_cand  <= w_cand_nxt;
            r_d     <= w_d_nxt;
            if (w_req_push) begin
                r_seq <= r_seq + 4'd1;
            end
            if (w_total_inc && !w_clr) begin
                r_total <= r_total + 8'd1;
            end
            // An S read clears the flags, but a same-cycle set takes priority
            if (w_clr) begin
                r_err_range <= 1'b0;
                r_ovf       <= 1'b0;
                r_err_wrap  <= 1'b0;
            end else begin
                r_err_range <= w_rng_set  | (r_err_range & ~w_rd_s);
                r_ovf       <= w_ovf_set  | (r_ovf       & ~w_rd_s);
                r_err_wrap  <= w_wrap_set | (r_err_wrap  & ~w_rd_s);
            end
        end
    end

    // ---------------- FIFO pointers ----------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_req_wp  <= '0;
            r_req_rp  <= '0;
            r_req_cnt <= '0;
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
        end else if (w_clr) begin
            r_req_wp  <= '0;
            r_req_rp  <= '0;
            r_req_cnt <= '0;
            r_res_wp  <= '0;
            r_res_rp  <= '0;
            r_res_cnt <= '0;
        end else begin
            if (w_req_push) r_req_wp <= r_req_wp + c_RQ_AW'(1);
            if (w_req_pop)  r_req_rp <= r_req_rp + c_RQ_AW'(1);
            case ({w_req_push, w_req_pop})
                2'b10:   r_req_cnt <= r_req_cnt + (c_RQ_AW+1)'(1);
                2'b01:   r_req_cnt <= r_req_cnt - (c_RQ_AW+1)'(1);
                default: r_req_cnt <= r_req_cnt;
            endcase
            if (w_res_push_ok) r_res_wp <= r_res_wp + c_RS_AW'(1);
            if (w_res_pop)     r_res_rp <= r_res_rp + c_RS_AW'(1);
            case ({w_res_push_ok, w_res_pop})
                2'b10:   r_res_cnt <= r_res_cnt + (c_RS_AW+1)'(1);
                2'b01:   r_res_cnt <= r_res_cnt - (c_RS_AW+1)'(1);
                default: r_res_cnt <= r_res_cnt;
            endcase
        end
    end

    // FIFO payload storage needs no reset; occupancy is tracked by the counters
    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_k[r_req_wp]   <= w_k;
            r_req_tag[r_req_wp] <= r_seq;
        end
        if (w_res_push_ok) begin
            r_res_prime[r_res_wp] <= w_res_din;
            r_res_tag[r_res_wp]   <= r_tag;
        end
    end

    // ---------------- read data ----------------
    logic [31:0] w_w_word, w_s_word;

    assign w_w_word = w_res_empty ? 32'h0 : 32'({r_res_prime[r_res_rp], r_res_tag[r_res_rp]});
    assign w_s_word = {8'h00, r_total, 7'h00, r_state, r_err_wrap, r_ovf, r_err_range,
                       w_req_full, !w_res_empty, (r_state != c_IDLE)};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_sdata <= '0;
        end else if (w_rd_w) begin
            r_sdata <= w_w_word;
        end else if (w_rd_s) begin
            r_sdata <= w_s_word;
        end
    end

    assign sdata_out = r_sdata;

`ifdef PRIME_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= !w_res_empty || r_err_range || r_ovf || r_err_wrap;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: doc/gpio_prime_engine.md
Name: gpio_prime_engine

Overview:
Bus-mapped peripheral that computes the k-th prime by sequential trial division. It is a parametrised successor to the single-request prime finder. It adds:
- a request FIFO and a result FIFO, so several k values can be queued and their primes read back in order;
- parametrised widths, depth and register base;
- a synchronous strobe interface, sticky error/overflow flags, and an abort command.

It sits on the same saddress/srd/swr slave bus as the other emulated GPIO peripherals.

Parameters:
BASE_ADDR, 16'h00EC, address of the A (request) register. Other registers are at fixed offsets from it.
N_WIDTH, 10, width of the request index k.
W_WIDTH, 13, width of the prime result; must satisfy W_WIDTH+4 <= 32.
MAX_N, 1000, largest accepted k.
REQ_DEPTH, 4, request FIFO entries (power of 2, >= 2).
RES_DEPTH, 4, result FIFO entries (power of 2, >= 2).

Ports:
clk  in  1  system clock; all logic on rising edge.
n_reset  in  1  asynchronous active-low reset.
saddress  in  16  bus address, valid with srd/swr.
srd  in  1  read strobe, one clk cycle high per access.
swr  in  1  write strobe, one clk cycle high per access.
sdata_in  in  32  write data.
sdata_out  out  32  registered read data.
irq  out  1  present only with PRIME_IRQ_EN.

Behaviour:
Register map:
- BASE+0x00 (0xEC) A, write-only. sdata_in[N_WIDTH-1:0] = k.
  - 1 <= k <= MAX_N: k is pushed with tag = seq[3:0], then the 4-bit sequence counter seq increments.
  - Otherwise: no push, err_range set.
  - FIFO full: no push, overflow set, seq unchanged.
- BASE+0x08 (0xF4) CLR, write any value. Flushes both FIFOs, aborts the search (FSM to IDLE), clears sticky flags. Does not clear seq or total.
- BASE+0x10 (0xFC) W, read. If the result FIFO is non-empty: returns {zeros, prime[W_WIDTH-1:0] at [W_WIDTH+3:4], tag at [3:0]} and pops one entry. If empty: returns 0, no pop.
- BASE+0x18 (0x104) S, read. Bit fields:
  - [0] busy (FSM not IDLE)
  - [1] result FIFO non-empty
  - [2] request FIFO full
  - [3] err_range
  - [4] overflow
  - [5] err_wrap
  - [8:6] FSM state code
  - [23:16] total (primes delivered since reset, 8-bit, wraps)
  - Reading S clears bits [5:3] in the same cycle; a flag set in that same cycle stays set.
- Unmapped read: sdata_out holds its previous value.

Bus timing:
- sdata_out updates on the clk edge where srd is sampled high (1-cycle latency).
- srd and swr high together: the write is performed, the read is ignored.

FSM:
- IDLE(0): if the request FIFO is non-empty and the result FIFO is not full, pop. Load k and tag; set cand=2, cnt=0. Go to CAND.
- CAND(1):
  - cand==2 → PRIME.
  - cand even → COMP.
  - else d=3 → DIV.
- DIV(2): one divisor per cycle.
  - d*d > cand (2*W_WIDTH-bit product) → PRIME.
  - cand % d == 0 → COMP.
  - else d += 2.
- PRIME(3): cnt+1. If cnt+1 == k → PUSH; else next candidate.
- COMP(4): next candidate.
- Next candidate rule: cand+1 if cand==2, else cand+2. If that would exceed 2^W_WIDTH-1: set err_wrap, push prime=0 with the tag, go to IDLE.
- PUSH(5): write {cand, tag} to the result FIFO, total+1, go to IDLE.

Boundaries:
- A push and a pop on the same FIFO in the same cycle both take effect; a full FIFO accepts the push only if it is popped that cycle.
- Result FIFO full stalls at IDLE; no search starts.
- CLR during any state returns to IDLE next cycle; any partially computed result is discarded.
- Reset at any time: FIFOs empty, FSM IDLE, sdata_out=0, all flags/seq/total=0, irq=0.

Optional Feature:
PRIME_IRQ_EN.
- Defined: port irq exists, registered, high while the result FIFO is non-empty or any sticky flag is set. It drops the cycle after the condition clears.
- Undefined: no irq port and no related logic; the register map is unchanged.

Test Plan:
1. Reset, write A=1, poll S until [1]=1, read W → 0x00000020 (prime 2, tag 0); S[23:16]=1.
2. Write A=1000, wait, read W → prime field 7919 (0x1EEF), i.e. 0x0001EEF0 | tag.
3. Back-to-back writes A=3, A=4, A=5 → reads return 5, 7, 11 with tags 0, 1, 2 in order; S[0]=0 afterwards.
4. Write A=0 and A=1001 → no results; S read shows [3]=1, and a second S read shows [3]=0.
5. Hold the result FIFO full (no reads), write REQ_DEPTH+1 requests → S[4]=1; after draining, exactly RES_DEPTH+REQ_DEPTH results, none lost.
6. Start A=1000, write CLR after 50 cycles → S reads busy=0, [1]=0. Separately, assert n_reset mid-search → sdata_out=0 and all S fields 0.
